// File: rtl/semi_auto_nav_ctrl_pkg.sv
// Shared types for the semi-auto navigation controller: FSM states, command codes,
// detector bit positions and the state/command/motor mapping helpers.
package semi_auto_nav_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TURN_R   = 3'd1,
        ST_TURN_L   = 3'd2,
        ST_STRAIGHT = 3'd3,
        ST_UTURN    = 3'd4,
        ST_CONFIRM  = 3'd5
    } nav_state_e;

    typedef enum logic [1:0] {
        CMD_STRAIGHT = 2'b00,
        CMD_RIGHT    = 2'b01,
        CMD_LEFT     = 2'b10,
        CMD_BACK     = 2'b11
    } nav_cmd_e;

    localparam int unsigned DET_BACK  = 3;
    localparam int unsigned DET_FRONT = 2;
    localparam int unsigned DET_LEFT  = 1;
    localparam int unsigned DET_RIGHT = 0;

    function automatic nav_state_e cmd_to_state(input logic [1:0] code);
        nav_state_e s;
        case (code)
            CMD_STRAIGHT: s = ST_STRAIGHT;
            CMD_RIGHT:    s = ST_TURN_R;
            CMD_LEFT:     s = ST_TURN_L;
            default:      s = ST_UTURN;
        endcase
        return s;
    endfunction

    // Motor word ordering is {backward, forward, left, right}.
    function automatic logic [3:0] state_to_motor(input nav_state_e s);
        logic [3:0] m;
        case (s)
            ST_STRAIGHT: m = 4'b0100;
            ST_TURN_L:   m = 4'b0010;
            ST_TURN_R:   m = 4'b0001;
            ST_UTURN:    m = 4'b0001;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/semi_auto_nav_ctrl_fifo.sv
// nav_cmd_fifo: small synchronous command FIFO with occupancy count and a flush
// that overrides push and pop. DEPTH must be a power of 2.
module nav_cmd_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/semi_auto_nav_ctrl.sv
// Semi-auto driving controller: queues user commands, debounces wall detectors and
// runs a tick-timed manoeuvre FSM driving the motor-direction outputs.
module semi_auto_nav_ctrl
    import semi_auto_nav_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 1_000_000,
    parameter int unsigned TURN_TICKS    = 90,
    parameter int unsigned UTURN_TICKS   = 180,
    parameter int unsigned LEAVE_TICKS   = 45,
    parameter int unsigned CONFIRM_TICKS = 6,
    parameter int unsigned DEB_TICKS     = 3,
    parameter int unsigned STRAIGHT_MAX  = 2000,
    parameter int unsigned Q_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [3:0]                  det,
    input  logic                        cmd_valid,
    input  logic [1:0]                  cmd_code,
    output logic                        cmd_ready,
    input  logic                        cmd_abort,
    output logic                        move_forward,
    output logic                        move_backward,
    output logic                        turn_left,
    output logic                        turn_right,
    output logic [2:0]                  state_o,
    output logic [$clog2(Q_DEPTH):0]    q_count,
    output logic                        timeout
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEB_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int unsigned MX1     = (TURN_TICKS > UTURN_TICKS) ? TURN_TICKS : UTURN_TICKS;
    localparam int unsigned MX2     = (MX1 > LEAVE_TICKS) ? MX1 : LEAVE_TICKS;
    localparam int unsigned MX3     = (MX2 > CONFIRM_TICKS) ? MX2 : CONFIRM_TICKS;
    localparam int unsigned CNT_TOP = (MX3 > STRAIGHT_MAX) ? MX3 : STRAIGHT_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST      = DEB_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST     = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] UTURN_LAST    = CNT_W'(UTURN_TICKS - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST  = CNT_W'(CONFIRM_TICKS - 1);
    localparam logic [CNT_W-1:0] STRAIGHT_LAST = CNT_W'(STRAIGHT_MAX - 1);
    localparam logic [CNT_W-1:0] LEAVE_MIN     = CNT_W'(LEAVE_TICKS);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [3:0]       w_filt;
    logic             w_f;
    logic             w_l;
    logic             w_r;
    logic             w_unused_back;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_q_dout;

    nav_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [3:0]       r_motor;

    // Clock-enable tick; abort realigns the divider so tick phase restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset || cmd_abort) begin
            r_div <= '0;
        end else if (enable) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign w_tick = enable & (r_div == DIV_LAST);

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic             r_f;
        logic [DEB_W-1:0] r_run;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_f   <= 1'b0;
                r_run <= '0;
            end else if (w_tick) begin
                if (det[g] == r_f) begin
                    r_run <= '0;
                end else if (r_run == DEB_LAST) begin
                    r_f   <= det[g];
                    r_run <= '0;
                end else begin
                    r_run <= r_run + 1'b1;
                end
            end
        end

        assign w_filt[g] = r_f;
    end

    assign w_f           = w_filt[DET_FRONT];
    assign w_l           = w_filt[DET_LEFT];
    assign w_r           = w_filt[DET_RIGHT];
    assign w_unused_back = w_filt[DET_BACK];

    assign cmd_ready = enable & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = w_tick & ~cmd_abort & (r_state == ST_IDLE) & ~w_empty;

    nav_cmd_fifo #(
        .WIDTH (2),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (cmd_abort),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (cmd_code),
        .o_dout  (w_q_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    // The saturating increment is the default; any transition overrides it with a clear.
    always_ff @(posedge clk) begin
        if (reset || cmd_abort) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_tick) begin
                r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_state <= cmd_to_state(w_q_dout);
                            r_cnt   <= '0;
                        end
                    end
                    ST_TURN_R, ST_TURN_L: begin
                        if (r_cnt == TURN_LAST) begin
                            r_state <= ST_STRAIGHT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_UTURN: begin
                        if (r_cnt == UTURN_LAST) begin
                            r_state <= ST_STRAIGHT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_STRAIGHT: begin
                        if (w_f) begin
                            r_state <= ST_CONFIRM;
                            r_cnt   <= '0;
                        end else if ((r_cnt >= LEAVE_MIN) && !(w_l && w_r)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == STRAIGHT_LAST) begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                            r_timeout <= 1'b1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (r_cnt == CONFIRM_LAST) begin
                            r_cnt <= '0;
                            if (!w_f) begin
                                r_state <= ST_STRAIGHT;
                            end else if (w_l && w_r) begin
                                r_state <= ST_UTURN;
                            end else if (w_l) begin
                                r_state <= ST_TURN_R;
                            end else if (w_r) begin
                                r_state <= ST_TURN_L;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Abort clears the motor word on the same edge that forces IDLE.
    always_ff @(posedge clk) begin
        if (reset || cmd_abort || !enable) begin
            r_motor <= '0;
        end else begin
            r_motor <= state_to_motor(r_state);
        end
    end

    assign {move_backward, move_forward, turn_left, turn_right} = r_motor;
    assign state_o = r_state;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_semi_auto_nav_ctrl.sv
// Self-checking bench for semi_auto_nav_ctrl with small timing parameters.
module tb_semi_auto_nav_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_TR = 3'd1, S_TL = 3'd2,
                           S_ST = 3'd3, S_UT = 3'd4, S_CF = 3'd5;
    localparam logic [11:0] M_ALL = 12'hFFF;
    localparam logic [11:0] M_ST  = 12'h070;
    localparam logic [11:0] M_STQ = 12'h3F0;
    localparam logic [11:0] M_STT = 12'h870;

    logic       clk = 1'b0;
    logic       reset, enable, cmd_valid, cmd_abort;
    logic [3:0] det;
    logic [1:0] cmd_code;
    logic       cmd_ready, mf, mb, tl, tr, timeout;
    logic [2:0] state_o;
    logic [2:0] q_count;

    int n_checks = 0;
    int n_pass   = 0;
    int m_div    = 0;

    typedef struct {
        string       name;
        logic [11:0] val;
        logic [11:0] mask;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] d;
        logic [1:0] c;
        int         n;
        logic [2:0] st;
        logic [3:0] mo;
    } vec_t;
    vec_t tbl[10];

    semi_auto_nav_ctrl #(
        .CLK_DIV       (4),
        .TURN_TICKS    (5),
        .UTURN_TICKS   (8),
        .LEAVE_TICKS   (3),
        .CONFIRM_TICKS (2),
        .DEB_TICKS     (2),
        .STRAIGHT_MAX  (20),
        .Q_DEPTH       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .det           (det),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .cmd_ready     (cmd_ready),
        .cmd_abort     (cmd_abort),
        .move_forward  (mf),
        .move_backward (mb),
        .turn_left     (tl),
        .turn_right    (tr),
        .state_o       (state_o),
        .q_count       (q_count),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    // Reference tick phase: divider of 4, frozen while disabled, zeroed by reset/abort.
    always @(posedge clk) begin
        if (reset || cmd_abort) m_div <= 0;
        else if (enable)        m_div <= (m_div == 3) ? 0 : m_div + 1;
    end

    function automatic bit tb_tick();
        return enable && !reset && !cmd_abort && (m_div == 3);
    endfunction

    function automatic logic [11:0] snap();
        return {timeout, cmd_ready, q_count, state_o, mb, mf, tl, tr};
    endfunction

    function automatic logic [11:0] mk(input logic to, input logic rdy, input logic [2:0] qc,
                                       input logic [2:0] st, input logic [3:0] mo);
        return {to, rdy, qc, st, mo};
    endfunction

    task automatic expect_(input string nm, input logic [11:0] v, input logic [11:0] m);
        exp_t e;
        e.name = nm; e.val = v; e.mask = m;
        sb.push_back(e);
    endtask

    task automatic check_();
        exp_t e;
        logic [11:0] a;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: empty queue at check, got none required entry");
        end else begin
            e = sb.pop_front();
            a = snap();
            if ((a & e.mask) === (e.val & e.mask)) n_pass++;
            else $display("FAIL %s: got %h required %h (mask %h) at %0t",
                          e.name, a & e.mask, e.val & e.mask, e.mask, $time);
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] v, input logic [11:0] m);
        expect_(nm, v, m);
        check_();
    endtask

    task automatic step_tick();
        int g = 0;
        while (!tb_tick() && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            $display("FAIL tick_wait: got no tick in 50 clks, required one");
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step_tick();
    endtask

    task automatic push(input logic [1:0] code);
        int g = 0;
        cmd_code  = code;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            n_checks++;
            $display("FAIL push_wait: cmd_ready got 0 for 500 clks, required 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic abort_();
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input bit want_eq, input string nm);
        int g = 0;
        while (((state_o == s) != want_eq) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            n_checks++;
            $display("FAIL %s: got state %0d after 2000 clks, required change", nm, state_o);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0000, 2'b01, 1, S_TR, 4'b0001};
        tbl[1] = '{4'b0000, 2'b10, 1, S_TL, 4'b0010};
        tbl[2] = '{4'b0000, 2'b11, 1, S_UT, 4'b0001};
        tbl[3] = '{4'b0000, 2'b00, 1, S_ST, 4'b0100};
        tbl[4] = '{4'b0000, 2'b00, 5, S_IDLE, 4'b0000};
        tbl[5] = '{4'b0110, 2'b00, 4, S_TR, 4'b0001};
        tbl[6] = '{4'b0101, 2'b00, 4, S_TL, 4'b0010};
        tbl[7] = '{4'b0111, 2'b00, 4, S_UT, 4'b0001};
        tbl[8] = '{4'b0100, 2'b00, 4, S_IDLE, 4'b0000};
        tbl[9] = '{4'b0011, 2'b00, 6, S_ST, 4'b0100};

        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_abort = 1'b0;
        det = 4'b0000; cmd_code = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_state", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            abort_();
            det = tbl[i].d;
            ticks(3);
            expect_($sformatf("vec%0d", i), mk(0, 1, 0, tbl[i].st, tbl[i].mo), M_ALL);
            push(tbl[i].c);
            ticks(tbl[i].n);
            @(negedge clk);
            check_();
        end

        // Right turn lasts 5 ticks, then straight for LEAVE ticks, then idle.
        abort_(); det = 4'b0000; ticks(3);
        push(2'b01); ticks(1); @(negedge clk);
        chk("t1_turn_r", mk(0, 1, 0, S_TR, 4'b0001), M_ALL);
        ticks(4);
        chk("t1_still_turn", mk(0, 1, 0, S_TR, 4'b0001), M_ALL);
        ticks(1); @(negedge clk);
        chk("t1_straight", mk(0, 1, 0, S_ST, 4'b0100), M_ALL);
        ticks(3);
        chk("t1_still_straight", mk(0, 1, 0, S_ST, 4'b0100), M_ALL);
        ticks(1); @(negedge clk);
        chk("t1_idle", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);

        // One-tick front glitch is filtered; held front wall goes through CONFIRM.
        abort_(); det = 4'b0011; ticks(3);
        push(2'b00); ticks(2);
        det = 4'b0111; ticks(1);
        det = 4'b0011; ticks(3);
        chk("glitch_ignored", mk(0, 1, 0, S_ST, 4'b0000), M_ST);
        det = 4'b0110; ticks(3);
        chk("to_confirm", mk(0, 1, 0, S_CF, 4'b0000), M_ST);
        @(negedge clk);
        chk("confirm_out", mk(0, 1, 0, S_CF, 4'b0000), M_ALL);
        ticks(2);
        chk("confirm_turn_r", mk(0, 1, 0, S_TR, 4'b0000), M_ST);
        @(negedge clk);
        chk("confirm_turn_r_out", mk(0, 1, 0, S_TR, 4'b0001), M_ALL);

        // Queue fills at 4; held fifth offer is accepted later; FIFO order kept.
        abort_(); det = 4'b0000; ticks(3);
        push(2'b11); ticks(1);
        push(2'b01); push(2'b10); push(2'b00); push(2'b11);
        cmd_code = 2'b01; cmd_valid = 1'b1;
        @(negedge clk);
        chk("q_full", mk(0, 0, 4, S_UT, 4'b0001), M_ALL);
        expect_("order0", mk(0, 0, 0, S_TR, 4'b0000), M_ST);
        expect_("order1", mk(0, 0, 0, S_TL, 4'b0000), M_ST);
        expect_("order2", mk(0, 0, 0, S_ST, 4'b0000), M_ST);
        expect_("order3", mk(0, 0, 0, S_UT, 4'b0000), M_ST);
        expect_("order4", mk(0, 0, 0, S_TR, 4'b0000), M_ST);
        fork
            push(2'b01);
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_state(S_IDLE, 1'b1, "order_idle");
                    wait_state(S_IDLE, 1'b0, "order_busy");
                    check_();
                end
            end
        join

        // Abort mid left turn with three queued.
        abort_(); det = 4'b0000; ticks(3);
        push(2'b10); ticks(1);
        push(2'b01); push(2'b01); push(2'b01);
        chk("abort_pre", mk(0, 1, 3, S_TL, 4'b0000), M_STQ);
        abort_();
        chk("abort_post", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);

        // Watchdog: L and R walls, no front wall.
        abort_(); det = 4'b0011; ticks(3);
        push(2'b00); ticks(20);
        chk("wd_before", mk(0, 1, 0, S_ST, 4'b0000), M_STT);
        ticks(1);
        chk("wd_fire", mk(1, 1, 0, S_IDLE, 4'b0100), M_ALL);
        @(negedge clk);
        chk("wd_pulse_end", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);

        // Disable mid-turn freezes the turn; it resumes where it left off.
        abort_(); det = 4'b0000; ticks(3);
        push(2'b10); ticks(3);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("dis_frozen", mk(0, 0, 0, S_TL, 4'b0000), M_ALL);
        enable = 1'b1;
        ticks(2); @(negedge clk);
        chk("dis_resume", mk(0, 1, 0, S_TL, 4'b0010), M_ALL);
        ticks(1);
        chk("dis_turn_done", mk(0, 1, 0, S_ST, 4'b0000), M_ST);

        // Reset in the middle of a U-turn discards queued work.
        abort_(); det = 4'b0000; ticks(3);
        push(2'b11); push(2'b01); ticks(3);
        chk("rst_pre", mk(0, 1, 0, S_UT, 4'b0000), M_ST);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_post", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);
        reset = 1'b0;
        ticks(3); @(negedge clk);
        chk("rst_queue_gone", mk(0, 1, 0, S_IDLE, 4'b0000), M_ALL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
